// File: rtl/bus_pkg.sv
// Shared definitions for the LSU data-bus request router.
//   state_e    : router FSM states (IDLE, REQ, WAIT, RSP)
//   N_TGT      : number of responders
//   SEL_W      : width of the responder select field
//   tgt_onehot : select index -> one-hot responder vector
package bus_pkg;

  localparam int N_TGT = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RSP  = 2'd3
  } state_e;

  function automatic logic [N_TGT-1:0] tgt_onehot(input logic [SEL_W-1:0] sel);
    tgt_onehot      = '0;
    tgt_onehot[sel] = 1'b1;
  endfunction

endpackage

// File: rtl/mux_4.sv
// 4:1 data multiplexer, shared with the read-return path.
//   sel_i      in  2    select
//   d0_i..d3_i in  DW   data inputs
//   y_o        out DW   selected data
module mux_4 #(
  parameter int DW = 32
) (
  input  logic [1:0]    sel_i,
  input  logic [DW-1:0] d0_i,
  input  logic [DW-1:0] d1_i,
  input  logic [DW-1:0] d2_i,
  input  logic [DW-1:0] d3_i,
  output logic [DW-1:0] y_o
);

  always_comb begin
    y_o = d0_i;
    case (sel_i)
      2'd0:    y_o = d0_i;
      2'd1:    y_o = d1_i;
      2'd2:    y_o = d2_i;
      2'd3:    y_o = d3_i;
      default: y_o = d0_i;
    endcase
  end

endmodule

// File: rtl/bus_demux_4.sv
// 1-initiator -> 4-responder request router for the RV32 LSU data bus.
// One outstanding transaction: the request is registered, forwarded to the
// responder picked by addr[SEL_LSB+1:SEL_LSB], and its response is returned
// to the initiator as a single-cycle pulse.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   m_req_valid/m_req_ready         initiator request handshake
//   m_addr/m_we/m_be/m_wdata        initiator request payload
//   m_rsp_valid/m_rdata/m_rsp_err   initiator response (pulse + held data)
//   s_req_valid[4]/s_req_ready[4]   per-responder request handshake
//   s_addr/s_we/s_be/s_wdata        shared registered request payload
//   s_rsp_valid[4]/s_rdata[4]       per-responder response
//
// Build option: BUS_DEMUX_TIMEOUT_EN adds a watchdog that ends a transaction
// with m_rsp_err=1 after TIMEOUT_CYC cycles in REQ+WAIT. Without it the
// router waits indefinitely and m_rsp_err is constant 0.
//
// state | meaning
// IDLE  | ready for a request, payload captured on m_req_valid
// REQ   | s_req_valid asserted toward the selected responder
// WAIT  | request taken, waiting for the selected responder's response
// RSP   | one-cycle m_rsp_valid pulse toward the initiator
module bus_demux_4
  import bus_pkg::*;
#(
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int SEL_LSB     = 28,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      m_req_valid,
  output logic                      m_req_ready,
  input  logic [AW-1:0]             m_addr,
  input  logic                      m_we,
  input  logic [DW/8-1:0]           m_be,
  input  logic [DW-1:0]             m_wdata,
  output logic                      m_rsp_valid,
  output logic [DW-1:0]             m_rdata,
  output logic                      m_rsp_err,
  output logic [N_TGT-1:0]          s_req_valid,
  input  logic [N_TGT-1:0]          s_req_ready,
  output logic [AW-1:0]             s_addr,
  output logic                      s_we,
  output logic [DW/8-1:0]           s_be,
  output logic [DW-1:0]             s_wdata,
  input  logic [N_TGT-1:0]          s_rsp_valid,
  input  logic [N_TGT-1:0][DW-1:0]  s_rdata
);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] sel_q;
  logic [AW-1:0]    addr_q;
  logic             we_q;
  logic [DW/8-1:0]  be_q;
  logic [DW-1:0]    wdata_q;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic [DW-1:0]    rdata_sel;
  logic             accept;
  logic             rsp_hit;
  logic             timeout;

  assign accept = (state_q == IDLE) && m_req_valid;

  mux_4 #(.DW(DW)) u_rdata_mux (
    .sel_i (sel_q),
    .d0_i  (s_rdata[0]),
    .d1_i  (s_rdata[1]),
    .d2_i  (s_rdata[2]),
    .d3_i  (s_rdata[3]),
    .y_o   (rdata_sel)
  );

`ifdef BUS_DEMUX_TIMEOUT_EN
  localparam int              CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // cnt_q counts completed cycles in REQ+WAIT; the last allowed cycle is
  // the one where it reads TIMEOUT_CYC-1.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if ((state_q == REQ) || (state_q == WAIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign timeout = ((state_q == REQ) || (state_q == WAIT)) && (cnt_q == CNT_LAST);

  // A real response in the same cycle as the watchdog expiry wins.
  always_comb begin
    err_d = err_q;
    if (rsp_hit) begin
      err_d = 1'b0;
    end else if (timeout) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign m_rsp_err = err_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign timeout            = 1'b0;
  assign m_rsp_err          = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    rsp_hit = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (m_req_valid) state_d = REQ;
      end
      REQ: begin
        if (s_req_ready[sel_q]) begin
          if (s_rsp_valid[sel_q]) begin
            state_d = RSP;
            rsp_hit = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (s_rsp_valid[sel_q]) begin
          state_d = RSP;
          rsp_hit = 1'b1;
        end
      end
      RSP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Stores return zero data rather than whatever the responder drives.
    if (rsp_hit) begin
      rdata_d = we_q ? '0 : rdata_sel;
    end else if (timeout) begin
      state_d = RSP;
      rdata_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      if (accept) begin
        sel_q   <= m_addr[SEL_LSB +: SEL_W];
        addr_q  <= m_addr;
        we_q    <= m_we;
        be_q    <= m_be;
        wdata_q <= m_wdata;
      end
    end
  end

  assign m_req_ready = (state_q == IDLE);
  assign m_rsp_valid = (state_q == RSP);
  assign m_rdata     = rdata_q;
  assign s_req_valid = (state_q == REQ) ? tgt_onehot(sel_q) : '0;
  assign s_addr      = addr_q;
  assign s_we        = we_q;
  assign s_be        = be_q;
  assign s_wdata     = wdata_q;

endmodule

// File: tb/tb_bus_demux_4.sv
// Bench for bus_demux_4: transaction-level reference model plus directed
// scenarios with hand-computed expectations.
module tb_bus_demux_4;

  localparam int DW      = 32;
  localparam int AW      = 32;
  localparam int SEL_LSB = 28;
  localparam int TMO     = 8;
`ifdef BUS_DEMUX_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic                 clk;
  logic                 rst_n;
  logic                 m_req_valid;
  logic                 m_req_ready;
  logic [AW-1:0]        m_addr;
  logic                 m_we;
  logic [DW/8-1:0]      m_be;
  logic [DW-1:0]        m_wdata;
  logic                 m_rsp_valid;
  logic [DW-1:0]        m_rdata;
  logic                 m_rsp_err;
  logic [3:0]           s_req_valid;
  logic [3:0]           s_req_ready;
  logic [AW-1:0]        s_addr;
  logic                 s_we;
  logic [DW/8-1:0]      s_be;
  logic [DW-1:0]        s_wdata;
  logic [3:0]           s_rsp_valid;
  logic [3:0][DW-1:0]   s_rdata;

  bus_demux_4 #(
    .DW(DW), .AW(AW), .SEL_LSB(SEL_LSB), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
    .m_addr(m_addr), .m_we(m_we), .m_be(m_be), .m_wdata(m_wdata),
    .m_rsp_valid(m_rsp_valid), .m_rdata(m_rdata), .m_rsp_err(m_rsp_err),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
    .s_addr(s_addr), .s_we(s_we), .s_be(s_be), .s_wdata(s_wdata),
    .s_rsp_valid(s_rsp_valid), .s_rdata(s_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one transaction in flight, tracked as "busy",
  // "request taken by responder", and "response due to initiator".
  bit          md_busy, md_issued, md_rsp;
  logic [1:0]  md_tgt;
  logic [31:0] md_addr, md_wdata, md_rdata;
  logic [3:0]  md_be;
  logic        md_we, md_err;
  int          md_age;

  function automatic bit md_got();
    if (!md_issued) return s_req_ready[md_tgt] && s_rsp_valid[md_tgt];
    return s_rsp_valid[md_tgt];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_busy <= 0; md_issued <= 0; md_rsp <= 0; md_tgt <= 0;
      md_addr <= 0; md_wdata <= 0; md_rdata <= 0; md_be <= 0;
      md_we <= 0; md_err <= 0; md_age <= 0;
    end else if (md_rsp) begin
      md_rsp  <= 0;
      md_busy <= 0;
    end else if (!md_busy) begin
      if (m_req_valid) begin
        md_busy   <= 1;
        md_issued <= 0;
        md_age    <= 0;
        md_tgt    <= m_addr[SEL_LSB +: 2];
        md_addr   <= m_addr;
        md_we     <= m_we;
        md_be     <= m_be;
        md_wdata  <= m_wdata;
      end
    end else begin
      md_age <= md_age + 1;
      if (!md_issued && s_req_ready[md_tgt]) md_issued <= 1;
      if (md_got()) begin
        md_rsp   <= 1;
        md_rdata <= md_we ? 32'd0 : s_rdata[md_tgt];
        md_err   <= 0;
      end else if (TMO_EN && (md_age + 1 == TMO)) begin
        md_rsp   <= 1;
        md_rdata <= 32'd0;
        md_err   <= 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_req_ready", 32'(m_req_ready), 32'(!md_busy));
      chk("s_req_valid", 32'(s_req_valid),
          (md_busy && !md_issued && !md_rsp) ? (32'd1 << md_tgt) : 32'd0);
      chk("m_rsp_valid", 32'(m_rsp_valid), 32'(md_rsp));
      chk("m_rdata", m_rdata, md_rdata);
      chk("m_rsp_err", 32'(m_rsp_err), 32'(md_err));
      chk("s_addr", s_addr, md_addr);
      chk("s_we", 32'(s_we), 32'(md_we));
      chk("s_be", 32'(s_be), 32'(md_be));
      chk("s_wdata", s_wdata, md_wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m_req_valid = 0;
    s_req_ready = 0;
    s_rsp_valid = 0;
  endtask

  task automatic issue(input logic [31:0] a, input logic we, input logic [3:0] be,
                       input logic [31:0] wd);
    m_req_valid = 1;
    m_addr      = a;
    m_we        = we;
    m_be        = be;
    m_wdata     = wd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int          got_c;
  logic        err_at;
  logic [31:0] rd_at;
  int          n_acc, n_rsp;

  initial begin
    rst_n = 1;
    idle_inputs();
    m_addr = 0; m_we = 0; m_be = 0; m_wdata = 0; s_rdata = '0;
    #1 rst_n = 0;
    #1 chk_en = 1;
    chk("rst_ready", 32'(m_req_ready), 32'd1);
    chk("rst_sreq", 32'(s_req_valid), 32'd0);
    chk("rst_rsp", 32'(m_rsp_valid), 32'd0);
    chk("rst_rdata", m_rdata, 32'd0);
    @(posedge clk);
    #3 rst_n = 1;

    // Load to target 2, with a stray response from target 1 during WAIT.
    tick(); issue(32'h2000_0010, 0, 4'hF, 32'h0);
    tick(); m_req_valid = 0; s_req_ready = 4'b0100;
    @(negedge clk); chk("load_sreq", 32'(s_req_valid), 32'h4);
    tick(); s_req_ready = 0; s_rsp_valid = 4'b0010; s_rdata[1] = 32'h0000_0BAD;
    tick(); s_rsp_valid = 4'b0100; s_rdata[2] = 32'hDEAD_BEEF;
    tick(); s_rsp_valid = 0;
    @(negedge clk);
    chk("load_rspv", 32'(m_rsp_valid), 32'd1);
    chk("load_rdata", m_rdata, 32'hDEAD_BEEF);
    chk("load_err", 32'(m_rsp_err), 32'd0);
    tick();
    @(negedge clk);
    chk("load_pulse", 32'(m_rsp_valid), 32'd0);
    chk("load_hold", m_rdata, 32'hDEAD_BEEF);

    // Store to target 3; responder drives junk data that must not appear.
    tick(); issue(32'h3000_0000, 1, 4'b0011, 32'h1234_5678);
    tick(); m_req_valid = 0; s_req_ready = 4'b1000; s_rdata[3] = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("st_sreq", 32'(s_req_valid), 32'h8);
    chk("st_be", 32'(s_be), 32'h3);
    chk("st_wdata", s_wdata, 32'h1234_5678);
    chk("st_we", 32'(s_we), 32'd1);
    tick(); s_req_ready = 0; s_rsp_valid = 4'b1000;
    tick(); s_rsp_valid = 0;
    @(negedge clk);
    chk("st_rspv", 32'(m_rsp_valid), 32'd1);
    chk("st_rdata", m_rdata, 32'd0);
    tick();

    // Target 0 accepts and responds in the REQ cycle: response on cycle 2.
    tick(); issue(32'h0000_0040, 0, 4'hF, 32'h0);
    tick(); m_req_valid = 0; s_req_ready = 4'b0001; s_rsp_valid = 4'b0001;
    s_rdata[0] = 32'hA5A5_0001;
    @(negedge clk); chk("fast_sreq", 32'(s_req_valid), 32'h1);
    tick(); s_req_ready = 0; s_rsp_valid = 0;
    @(negedge clk);
    chk("fast_rspv", 32'(m_rsp_valid), 32'd1);
    chk("fast_rdata", m_rdata, 32'hA5A5_0001);
    tick();

    // Back-to-back requests held high: accepts on cycles 0,3,6.
    tick(); issue(32'h1000_0004, 0, 4'hF, 32'h0);
    s_req_ready = 4'hF; s_rsp_valid = 4'hF;
    n_acc = 0; n_rsp = 0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      s_rdata[1] = 32'h0000_1000 + 32'(i);
      @(negedge clk);
      if (m_req_ready && m_req_valid) n_acc++;
      if (m_rsp_valid) n_rsp++;
    end
    chk("b2b_accepts", 32'(n_acc), 32'd3);
    chk("b2b_rsps", 32'(n_rsp), 32'd2);
    tick(); idle_inputs();
    tick(); tick();

    // Reset while waiting: outputs drop at once and no response follows.
    tick(); issue(32'h2000_0000, 0, 4'hF, 32'h0);
    tick(); m_req_valid = 0; s_req_ready = 4'b0100;
    tick(); s_req_ready = 0;
    #2 rst_n = 0;
    #1;
    chk("rstw_ready", 32'(m_req_ready), 32'd1);
    chk("rstw_sreq", 32'(s_req_valid), 32'd0);
    chk("rstw_rsp", 32'(m_rsp_valid), 32'd0);
    chk("rstw_rdata", m_rdata, 32'd0);
    chk("rstw_addr", s_addr, 32'd0);
    tick(); s_rsp_valid = 4'b0100; s_rdata[2] = 32'h7777_7777;
    #2 s_rsp_valid = 0;
    rst_n = 1;
    tick();
    tick(); issue(32'h0000_0000, 0, 4'hF, 32'h0);
    tick(); m_req_valid = 0; s_req_ready = 4'b0001;
    tick(); s_req_ready = 0; s_rsp_valid = 4'b0001; s_rdata[0] = 32'hCAFE_F00D;
    tick(); s_rsp_valid = 0;
    @(negedge clk);
    chk("post_rspv", 32'(m_rsp_valid), 32'd1);
    chk("post_rdata", m_rdata, 32'hCAFE_F00D);
    tick();

    // Target 1 never answers: watchdog error, or an indefinite wait.
    tick(); issue(32'h1000_0000, 0, 4'hF, 32'h0);
    tick(); m_req_valid = 0;
    got_c = -1; err_at = 0; rd_at = 32'hFFFF_FFFF;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (m_rsp_valid && got_c < 0) begin
        got_c  = c;
        err_at = m_rsp_err;
        rd_at  = m_rdata;
      end
      tick();
      if (TMO_EN && c == 12) begin
        s_req_ready = 4'b0010; s_rsp_valid = 4'b0010; s_rdata[1] = 32'h5555_AAAA;
      end else begin
        s_req_ready = 0; s_rsp_valid = 0;
      end
    end
    chk("tmo_cycle", 32'(got_c), TMO_EN ? 32'(TMO + 1) : 32'hFFFF_FFFF);
    chk("tmo_err", 32'(err_at), TMO_EN ? 32'd1 : 32'd0);
    chk("tmo_rdata", rd_at, TMO_EN ? 32'd0 : 32'hFFFF_FFFF);
    @(negedge clk);
    chk("tmo_ready_end", 32'(m_req_ready), TMO_EN ? 32'd1 : 32'd0);
    tick();
    #2 rst_n = 0;
    #2 rst_n = 1;
    tick(); tick();

    @(negedge clk);
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
